// File: rtl/pen_fb_pkg.sv
// Shared constants and read-FSM state type for the packed edge-bitmap frame buffer.
package pen_fb_pkg;

  localparam int FRAME_BYTES = 5280;
  localparam int FB_ADDR_W   = $clog2(FRAME_BYTES);
  localparam int FB_DROP_W   = 8;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_WAIT,
    RD_FETCH,
    RD_LOAD,
    RD_SEND
  } rd_state_t;

endpackage

// File: rtl/fb_rd_streamer.sv
// Read side of the ping-pong buffer: waits for a granted frame, then streams it byte by byte
// to the UART TX handshake (fetch, load, send per byte).
module fb_rd_streamer
  import pen_fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_req,
  input  logic              rdy_valid,
  input  logic              wr_frame_tick,
  input  logic              rd_bank,
  input  logic [7:0]        mem_rdata,
  input  logic              tx_ready,
  output logic              grant,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W:0]   mem_raddr,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  rd_state_t         state;
  rd_state_t         state_next;
  logic [ADDR_W-1:0] rd_addr;

  // A tick in the same cycle wins so the grant picks up the newer frame next cycle.
  assign grant = (state == RD_WAIT) && rdy_valid && !wr_frame_tick;
  assign done  = (state == RD_SEND) && tx_ready && tx_last;
  assign busy  = (state != RD_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= RD_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RD_IDLE:  if (frame_req) state_next = RD_WAIT;
      RD_WAIT:  if (grant) state_next = RD_FETCH;
      RD_FETCH: state_next = RD_LOAD;
      RD_LOAD:  state_next = RD_SEND;
      RD_SEND:  if (tx_ready) state_next = tx_last ? RD_IDLE : RD_FETCH;
      default:  state_next = RD_IDLE;
    endcase
  end

  // Output byte is held stable in RD_SEND until the UART takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr   <= '0;
      mem_raddr <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_last   <= 1'b0;
    end else begin
      case (state)
        RD_WAIT:  if (grant) rd_addr <= '0;
        RD_FETCH: mem_raddr <= {rd_bank, rd_addr};
        RD_LOAD: begin
          tx_data  <= mem_rdata;
          tx_valid <= 1'b1;
          tx_last  <= (rd_addr == LAST_ADDR);
        end
        RD_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (tx_last) tx_last <= 1'b0;
            else         rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame buffer controller: owns write/read bank selection, the frame swap and the
// dropped-frame policy; the byte streaming itself lives in fb_rd_streamer.
module fb_pingpong_ctrl
  import pen_fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DROP_W = FB_DROP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_frame_tick,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W:0]   mem_raddr,
  input  logic [7:0]        mem_rdata,
  input  logic              frame_req,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_last,
  output logic              frame_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  logic wr_bank;
  logic rd_bank;
  logic rdy_bank;
  logic rdy_valid;
  logic rd_active;
  logic grant;
  logic done;
  logic drop_hit;

  assign mem_we      = wr_we;
  assign mem_waddr   = {wr_bank, wr_addr};
  assign mem_wdata   = wr_data;
  assign frame_ready = rdy_valid;

  // Finishing into the bank being streamed would overwrite it, so that frame is discarded.
  assign drop_hit = rd_active && (rd_bank != wr_bank);

  // A swap replaces any older unsent frame; grant and tick never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      rdy_bank  <= 1'b0;
      rdy_valid <= 1'b0;
      rd_active <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (wr_frame_tick) begin
        if (drop_hit) begin
          if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
        end else begin
          rdy_bank  <= wr_bank;
          rdy_valid <= 1'b1;
          wr_bank   <= ~wr_bank;
        end
      end
      if (grant) begin
        rd_bank   <= rdy_bank;
        rdy_valid <= 1'b0;
        rd_active <= 1'b1;
      end
      if (done) rd_active <= 1'b0;
    end
  end

  fb_rd_streamer #(
    .ADDR_W(ADDR_W)
  ) u_streamer (
    .clk           (clk),
    .reset         (reset),
    .frame_req     (frame_req),
    .rdy_valid     (rdy_valid),
    .wr_frame_tick (wr_frame_tick),
    .rd_bank       (rd_bank),
    .mem_rdata     (mem_rdata),
    .tx_ready      (tx_ready),
    .grant         (grant),
    .done          (done),
    .busy          (busy),
    .mem_raddr     (mem_raddr),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_last       (tx_last)
  );

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Directed bench for fb_pingpong_ctrl with a behavioural dual-bank RAM model.
module tb_fb_pingpong_ctrl;
  import pen_fb_pkg::*;

  localparam int AW = FB_ADDR_W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_we = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_frame_tick = 1'b0;
  logic          mem_we;
  logic [AW:0]   mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW:0]   mem_raddr;
  logic [7:0]    mem_rdata;
  logic          frame_req = 1'b0;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_last;
  logic          frame_ready;
  logic          busy;
  logic [7:0]    drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [0:(1<<(AW+1))-1];
  logic [7:0] rx_data[$];
  int         rx_addr[$];
  bit         rx_bank[$];
  bit         rx_last[$];
  int         stall_changes;

  fb_pingpong_ctrl dut (
    .clk(clk), .reset(reset), .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_tick(wr_frame_tick), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .frame_req(frame_req), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .frame_ready(frame_ready), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // RAM data follows the registered read address, one cycle after the fetch.
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  function automatic logic [7:0] pat(input int key, input int a);
    logic [7:0] k;
    k = (key == 0) ? 8'hA5 : 8'(8'h5A + key * 29);
    return 8'(a) ^ k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_we = 1'b0; wr_frame_tick = 1'b0; frame_req = 1'b0; tx_ready = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic write_bytes(input int n, input int key);
    for (int a = 0; a < n; a++) begin
      wr_we = 1'b1; wr_addr = AW'(a); wr_data = pat(key, a);
      step();
    end
    wr_we = 1'b0;
    step();
  endtask

  task automatic pulse_tick();
    wr_frame_tick = 1'b1; step(); wr_frame_tick = 1'b0;
  endtask

  task automatic pulse_req();
    frame_req = 1'b1; step(); frame_req = 1'b0;
  endtask

  // Accepts n bytes with tx_ready high one cycle in 'period'; records bytes and stall violations.
  task automatic collect(input int n, input int period, input int budget, input bit clear);
    int got; int cyc; logic pv; logic pr; logic [7:0] pd; logic pl;
    got = 0; cyc = 0;
    if (clear) begin
      rx_data.delete(); rx_addr.delete(); rx_bank.delete(); rx_last.delete(); stall_changes = 0;
    end
    while (got < n && cyc < budget) begin
      tx_ready = ((cyc % period) == period - 1);
      if (tx_valid === 1'b1 && tx_ready) begin
        rx_data.push_back(tx_data); rx_addr.push_back(int'(mem_raddr[AW-1:0]));
        rx_bank.push_back(mem_raddr[AW]); rx_last.push_back(tx_last);
        got++;
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
      step(); cyc++;
      if (pv === 1'b1 && !pr && (tx_valid !== 1'b1 || tx_data !== pd || tx_last !== pl))
        stall_changes++;
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    wr_addr = 13'h1234; wr_data = 8'h5C; tx_ready = 1'b1;
    do_reset();
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_tx_valid: got %b want 0", tx_valid); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_tx_data: got %h want 00", tx_data); end
    vectors++; if (tx_last !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_tx_last: got %b want 0", tx_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (frame_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_frame_ready: got %b want 0", frame_ready); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    vectors++; if (mem_raddr !== '0) begin miscompares++; $display("[TB] FAIL rst_mem_raddr: got %h want 0", mem_raddr); end
    #1;
    vectors++; if (mem_waddr !== {1'b0, 13'h1234}) begin miscompares++; $display("[TB] FAIL wr_pass_addr: got %h want 1234", mem_waddr); end
    vectors++; if (mem_wdata !== 8'h5C || mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_pass_data: got %h/%b want 5c/0", mem_wdata, mem_we); end
    wr_we = 1'b1; #1;
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_pass_we: got %b want 1", mem_we); end
    wr_we = 1'b0;
  endtask

  task automatic test_full_frame();
    int bd; int ba; int bb; int bl;
    bd = 0; ba = 0; bb = 0; bl = 0;
    write_bytes(FRAME_BYTES, 0);
    pulse_tick();
    vectors++; if (frame_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_frame_ready: got %b want 1", frame_ready); end
    pulse_req();
    collect(FRAME_BYTES, 1, FRAME_BYTES * 4 + 20, 1'b1);
    vectors++; if (rx_data.size() != FRAME_BYTES) begin miscompares++; $display("[TB] FAIL full_count: got %0d want %0d", rx_data.size(), FRAME_BYTES); end
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== pat(0, i)) bd++;
      if (rx_addr[i] != i) ba++;
      if (rx_bank[i] != 1'b0) bb++;
      if (rx_last[i] != (i == FRAME_BYTES - 1)) bl++;
    end
    vectors++; if (bd != 0) begin miscompares++; $display("[TB] FAIL full_data: got %0d bad bytes want 0", bd); end
    vectors++; if (ba != 0) begin miscompares++; $display("[TB] FAIL full_addr_order: got %0d bad addrs want 0", ba); end
    vectors++; if (bb != 0) begin miscompares++; $display("[TB] FAIL full_bank: got %0d bank1 reads want 0", bb); end
    vectors++; if (bl != 0) begin miscompares++; $display("[TB] FAIL full_last: got %0d bad tx_last want 0", bl); end
    vectors++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL full_idle: got busy=%b valid=%b want 0/0", busy, tx_valid); end
    wr_addr = '0; #1;
    vectors++; if (mem_waddr[AW] !== 1'b1) begin miscompares++; $display("[TB] FAIL full_wr_bank: got %b want 1", mem_waddr[AW]); end
  endtask

  task automatic test_req_waits();
    int bad_busy; int saw_valid; int bd;
    bad_busy = 0; saw_valid = 0; bd = 0;
    do_reset();
    pulse_req();
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b1) bad_busy++;
      if (tx_valid !== 1'b0) saw_valid++;
      step();
    end
    vectors++; if (bad_busy != 0) begin miscompares++; $display("[TB] FAIL wait_busy: got %0d idle cycles want 0", bad_busy); end
    vectors++; if (saw_valid != 0) begin miscompares++; $display("[TB] FAIL wait_no_valid: got %0d valid cycles want 0", saw_valid); end
    write_bytes(64, 1);
    pulse_tick();
    step();
    vectors++; if (frame_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wait_grant: got frame_ready=%b want 0", frame_ready); end
    step();
    vectors++; if (tx_valid !== 1'b0 || mem_raddr !== '0) begin miscompares++; $display("[TB] FAIL wait_lat_early: got valid=%b raddr=%h want 0/0", tx_valid, mem_raddr); end
    step();
    vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wait_lat: got valid=%b want 1", tx_valid); end
    collect(64, 1, 300, 1'b1);
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== pat(1, i) || rx_bank[i] != 1'b0 || rx_addr[i] != i) bd++;
    vectors++; if (rx_data.size() != 64 || bd != 0) begin miscompares++; $display("[TB] FAIL wait_stream: got %0d bytes %0d bad want 64/0", rx_data.size(), bd); end
  endtask

  task automatic test_throttle_drop();
    int bd;
    bd = 0;
    do_reset();
    write_bytes(64, 2);
    pulse_tick();
    pulse_req();
    collect(20, 7, 260, 1'b1);
    pulse_tick();
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL thr_drop_cnt: got %0d want 1", drop_cnt); end
    vectors++; if (frame_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL thr_state: got ready=%b busy=%b want 0/1", frame_ready, busy); end
    wr_addr = '0; #1;
    vectors++; if (mem_waddr[AW] !== 1'b1) begin miscompares++; $display("[TB] FAIL thr_wr_bank: got %b want 1", mem_waddr[AW]); end
    collect(20, 7, 260, 1'b0);
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== pat(2, i) || rx_bank[i] != 1'b0 || rx_addr[i] != i) bd++;
    vectors++; if (rx_data.size() != 40 || bd != 0) begin miscompares++; $display("[TB] FAIL thr_stream: got %0d bytes %0d bad want 40/0", rx_data.size(), bd); end
    vectors++; if (stall_changes != 0) begin miscompares++; $display("[TB] FAIL thr_stall_stable: got %0d changes want 0", stall_changes); end
  endtask

  task automatic test_two_ticks();
    int bd;
    bd = 0;
    do_reset();
    write_bytes(64, 4);
    pulse_tick();
    write_bytes(64, 5);
    pulse_tick();
    vectors++; if (frame_ready !== 1'b1 || drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL two_ready: got ready=%b drop=%0d want 1/0", frame_ready, drop_cnt); end
    wr_addr = '0; #1;
    vectors++; if (mem_waddr[AW] !== 1'b0) begin miscompares++; $display("[TB] FAIL two_wr_bank: got %b want 0", mem_waddr[AW]); end
    pulse_req();
    collect(64, 1, 300, 1'b1);
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== pat(5, i) || rx_bank[i] != 1'b1 || rx_addr[i] != i) bd++;
    vectors++; if (rx_data.size() != 64 || bd != 0) begin miscompares++; $display("[TB] FAIL two_stream_bank1: got %0d bytes %0d bad want 64/0", rx_data.size(), bd); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL two_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_tick_vs_grant();
    int bd;
    bd = 0;
    do_reset();
    write_bytes(64, 6);
    pulse_tick();
    write_bytes(64, 7);
    frame_req = 1'b1; step();
    frame_req = 1'b0; wr_frame_tick = 1'b1; step();
    wr_frame_tick = 1'b0;
    vectors++; if (frame_ready !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL tvg_deferred: got ready=%b busy=%b want 1/1", frame_ready, busy); end
    step();
    vectors++; if (frame_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL tvg_grant: got ready=%b want 0", frame_ready); end
    step();
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL tvg_early_valid: got %b want 0", tx_valid); end
    step();
    vectors++; if (tx_valid !== 1'b1 || mem_raddr !== {1'b1, 13'd0}) begin miscompares++; $display("[TB] FAIL tvg_new_bank: got valid=%b raddr=%h want 1/2000", tx_valid, mem_raddr); end
    collect(16, 1, 100, 1'b1);
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== pat(7, i) || rx_bank[i] != 1'b1) bd++;
    vectors++; if (rx_data.size() != 16 || bd != 0) begin miscompares++; $display("[TB] FAIL tvg_stream: got %0d bytes %0d bad want 16/0", rx_data.size(), bd); end
  endtask

  task automatic test_reset_midstream();
    int bd; int k;
    bd = 0; k = 0;
    do_reset();
    write_bytes(128, 8);
    pulse_tick();
    pulse_req();
    collect(100, 1, 500, 1'b1);
    pulse_tick();
    while (tx_valid !== 1'b1 && k < 10) begin step(); k++; end
    vectors++; if (rx_data.size() != 100 || tx_valid !== 1'b1 || drop_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL mid_setup: got %0d bytes valid=%b drop=%0d want 100/1/1", rx_data.size(), tx_valid, drop_cnt); end
    reset = 1'b1; step();
    vectors++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_last !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_tx: got %b/%h/%b want 0/00/0", tx_valid, tx_data, tx_last); end
    vectors++; if (busy !== 1'b0 || frame_ready !== 1'b0 || drop_cnt !== 8'd0 || mem_raddr !== '0) begin miscompares++; $display("[TB] FAIL mid_rst_ctl: got busy=%b ready=%b drop=%0d raddr=%h want 0/0/0/0", busy, frame_ready, drop_cnt, mem_raddr); end
    reset = 1'b0;
    wr_addr = '0; #1;
    vectors++; if (mem_waddr[AW] !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_wr_bank: got %b want 0", mem_waddr[AW]); end
    write_bytes(16, 9);
    pulse_tick();
    pulse_req();
    collect(8, 1, 60, 1'b1);
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== pat(9, i) || rx_addr[i] != i || rx_bank[i] != 1'b0) bd++;
    vectors++; if (rx_data.size() != 8 || bd != 0) begin miscompares++; $display("[TB] FAIL mid_restart: got %0d bytes %0d bad want 8/0", rx_data.size(), bd); end
  endtask

  initial begin
    for (int i = 0; i < (1 << (AW + 1)); i++) mem[i] = 8'h00;
    step();
    test_reset();
    test_full_frame();
    test_req_waits();
    test_throttle_drop();
    test_two_ticks();
    test_tick_vs_grant();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
